// File: rtl/pixel_serializer_8to1_if.sv
// Word-in / pixel-out stream bundle for pixel_serializer_8to1.
// master = producer of words and consumer of pixels; slave = the serializer.
interface pixel_serializer_8to1_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic [7:0] in4;
    logic [7:0] in5;
    logic [7:0] in6;
    logic [7:0] in7;
    logic [7:0] in8;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       pix_ready;
    logic       sof;
    logic       eol;
    logic       frame_done;

    modport master (
        output in_valid, in1, in2, in3, in4, in5, in6, in7, in8, pix_ready,
        input  in_ready, pix_out, pix_valid, sof, eol, frame_done
    );

    modport slave (
        input  in_valid, in1, in2, in3, in4, in5, in6, in7, in8, pix_ready,
        output in_ready, pix_out, pix_valid, sof, eol, frame_done
    );
endinterface

// File: rtl/pixel_serializer_8to1.sv
// Buffers 8-pixel words in a small FIFO and emits one pixel per clock,
// tagging start-of-frame / end-of-line and pulsing at end of frame.
module pixel_serializer_8to1 #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    pixel_serializer_8to1_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [63:0]   cur_word_q, cur_word_d;
    logic          cur_valid_q, cur_valid_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          frame_done_q, frame_done_d;

    logic push;
    logic pop;
    logic fire;
    logic word_done;

    assign bus.in_ready = (count_q != CNT_FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign fire         = cur_valid_q && bus.pix_ready;
    assign word_done    = fire && (idx_q == 3'd7);
    // No bypass: a word pushed this cycle is only poppable once count_q reflects it.
    assign pop          = (count_q != '0) && (!cur_valid_q || word_done);

    assign bus.pix_valid  = cur_valid_q;
    assign bus.pix_out    = cur_valid_q ? cur_word_q[{idx_q, 3'b000} +: 8] : '0;
    assign bus.sof        = cur_valid_q && (col_q == '0) && (row_q == '0);
    assign bus.eol        = cur_valid_q && (col_q == COL_LAST);
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in8, bus.in7, bus.in6, bus.in5,
                                bus.in4, bus.in3, bus.in2, bus.in1};
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cur_word_d   = cur_word_q;
        cur_valid_d  = cur_valid_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            cur_word_d  = mem_q[rd_ptr_q];
            cur_valid_d = 1'b1;
            idx_d       = '0;
        end else if (word_done) begin
            cur_valid_d = 1'b0;
            idx_d       = '0;
        end else if (fire) begin
            idx_d = idx_q + 1'b1;
        end

        if (fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_word_q   <= '0;
            cur_valid_q  <= 1'b0;
            idx_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cur_word_q   <= cur_word_d;
            cur_valid_q  <= cur_valid_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_pixel_serializer_8to1.sv
// Scoreboard bench: accepted words queue their pixels; a negedge monitor
// checks pixel order, sof/eol and frame_done against a frame-position model.
module tb_pixel_serializer_8to1;
    localparam int unsigned W = 16;
    localparam int unsigned H = 2;
    localparam int unsigned D = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    pixel_serializer_8to1_if bus();

    pixel_serializer_8to1 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .FIFO_DEPTH(D)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  sb[$];
    int unsigned npix   = 0;
    logic        fd_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pixels leave in acceptance order; position within the
    // frame is simply the running pixel count modulo W*H.
    always @(negedge CLK) begin
        int unsigned pos;
        if (!RST_N) begin
            sb.delete();
            npix   = 0;
            fd_exp = 1'b0;
        end else begin
            chk("frame_done", {31'd0, bus.frame_done}, {31'd0, fd_exp});
            fd_exp = 1'b0;
            if (bus.pix_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel: got %0h expected none", bus.pix_out);
                end else begin
                    pos = npix % (W * H);
                    chk("pix_out", {24'd0, bus.pix_out}, {24'd0, sb[0]});
                    chk("sof", {31'd0, bus.sof}, {31'd0, (pos == 0)});
                    chk("eol", {31'd0, bus.eol}, {31'd0, ((pos % W) == W - 1)});
                    if (bus.pix_ready) begin
                        void'(sb.pop_front());
                        fd_exp = (pos == W * H - 1);
                        npix++;
                    end
                end
            end else begin
                chk("idle_pix_out", {24'd0, bus.pix_out}, 32'd0);
                chk("idle_markers", {30'd0, bus.sof, bus.eol}, 32'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(bus.in1); sb.push_back(bus.in2);
                sb.push_back(bus.in3); sb.push_back(bus.in4);
                sb.push_back(bus.in5); sb.push_back(bus.in6);
                sb.push_back(bus.in7); sb.push_back(bus.in8);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_word(input logic [63:0] w);
        {bus.in8, bus.in7, bus.in6, bus.in5, bus.in4, bus.in3, bus.in2, bus.in1} = w;
    endtask

    task automatic rand_word();
        set_word({$urandom, $urandom});
    endtask

    task automatic drain(input string name, output int fdc);
        int n;
        fdc = 0;
        bus.pix_ready = 1'b1;
        bus.in_valid  = 1'b0;
        n = 0;
        while (n < 600 && (sb.size() != 0 || bus.pix_valid)) begin
            tick();
            if (bus.frame_done) fdc++;
            n++;
        end
        chk(name, sb.size(), 32'd0);
    endtask

    task automatic push_words(input int cnt, input logic [63:0] first);
        int acc;
        int n;
        acc = 0;
        n   = 0;
        set_word(first);
        bus.in_valid = 1'b1;
        while (acc < cnt && n < 100) begin
            if (bus.in_ready) acc++;
            tick();
            rand_word();
            n++;
        end
        bus.in_valid = 1'b0;
        chk("push_budget", acc, cnt);
    endtask

    initial begin
        int accepted;
        int fdc;
        int n;

        bus.pix_ready = 1'b1;
        bus.in_valid  = 1'b1;
        rand_word();

        // Reset with in_valid held high
        RST_N = 1'b0;
        tick();
        tick();
        chk("rst_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("rst_pix_out", {24'd0, bus.pix_out}, 32'd0);
        chk("rst_markers", {29'd0, bus.sof, bus.eol, bus.frame_done}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        RST_N = 1'b1;
        tick();
        tick();
        chk("rst_no_capture", {31'd0, bus.pix_valid}, 32'd0);

        // Single word: latency and sof on first pixel
        set_word(64'h0807060504030201);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("lat_valid", {31'd0, bus.pix_valid}, 32'd1);
        chk("lat_pix", {24'd0, bus.pix_out}, 32'h01);
        chk("lat_sof", {31'd0, bus.sof}, 32'd1);
        repeat (8) tick();
        chk("single_end_valid", {31'd0, bus.pix_valid}, 32'd0);

        // Backpressure: output register plus FIFO_DEPTH words
        bus.pix_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            rand_word();
            bus.in_valid = 1'b1;
            if (bus.in_ready) accepted++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", accepted, D + 1);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        drain("bp_drain", fdc);

        // Mid-word stall
        set_word(64'h0807060504030201);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (n < 20 && !(bus.pix_valid && bus.pix_out == 8'h03)) begin
            tick();
            n++;
        end
        bus.pix_ready = 1'b0;
        chk("stall_seen", {24'd0, bus.pix_out}, 32'h03);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {24'd0, bus.pix_out}, 32'h03);
        end
        bus.pix_ready = 1'b1;
        tick();
        chk("stall_next", {24'd0, bus.pix_out}, 32'h04);
        drain("stall_drain", fdc);

        // Frame wrap from a fresh frame: 5 words = 40 pixels, one frame end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        bus.pix_ready = 1'b1;
        push_words(5, 64'h0807060504030201);
        drain("wrap_drain", fdc);
        chk("wrap_fd_pulses", fdc, 32'd1);

        // Reset mid-word with two words still buffered
        bus.pix_ready = 1'b0;
        push_words(3, 64'h0807060504030201);
        bus.pix_ready = 1'b1;
        n = 0;
        while (n < 20 && !(bus.pix_valid && bus.pix_out == 8'h05)) begin
            tick();
            n++;
        end
        bus.pix_ready = 1'b0;
        chk("rmid_seen", {24'd0, bus.pix_out}, 32'h05);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("rmid_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("rmid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.pix_ready = 1'b1;
        tick();
        tick();
        chk("rmid_empty", {31'd0, bus.pix_valid}, 32'd0);
        set_word(64'h1817161514131211);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("rmid_sof", {31'd0, bus.sof}, 32'd1);
        chk("rmid_first", {24'd0, bus.pix_out}, 32'h11);
        drain("rmid_drain", fdc);

        // Random traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            rand_word();
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.pix_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand_drain", fdc);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_serializer_8to1.md
Name: pixel_serializer_8to1

Overview:
- Downstream stage of top_module_imp; consumes its eight parallel 8-bit outputs (out1..out8) as one 8-pixel word per transfer.
- Buffers words in a small FIFO and emits one pixel per clock on a valid/ready stream.
- Tags each pixel with start-of-frame and end-of-line markers, and pulses at end of frame, for display/UART/VGA back-ends.

Parameters:
- IMG_WIDTH, 64, pixels per line; must be a multiple of 8 and >= 8.
- IMG_HEIGHT, 64, lines per frame; >= 1.
- FIFO_DEPTH, 4, number of 64-bit words held in the input FIFO; power of 2, >= 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- in_valid  in  1  word on in1..in8 is valid.
- in_ready  out  1  block can accept a word this cycle.
- in1..in8  in  8 each  pixels of the word; in1 is emitted first, in8 last.
- pix_out  out  8  current output pixel.
- pix_valid  out  1  pix_out is valid.
- pix_ready  in  1  downstream accepts pix_out this cycle.
- sof  out  1  qualifies pix_out as pixel (row 0, col 0).
- eol  out  1  qualifies pix_out as the last pixel of a line (col IMG_WIDTH-1).
- frame_done  out  1  one-cycle pulse on the edge that accepts the last pixel of a frame.

Behaviour:
- Reset (RST_N=0 at an edge): FIFO emptied (count=0, pointers=0); output register cleared; idx=0; col=0; row=0.
  - Outputs after reset: pix_out=0, pix_valid=0, sof=0, eol=0, frame_done=0, in_ready=1.
- Reset mid-operation discards all buffered and partially emitted words. No partial-frame marker is produced.
- Input handshake:
  - in_ready = (count != FIFO_DEPTH); this is combinational from the count register only.
  - A push occurs when in_valid && in_ready at an edge; in1..in8 are captured as one word.
  - When in_ready=0, in1..in8 and in_valid are ignored; no overflow is possible.
- Output register: holds one word (cur_word), a flag cur_valid, and idx (3 bits).
  - pix_valid = cur_valid.
  - pix_out = cur_word pixel[idx], where idx 0 corresponds to in1. pix_out is 0 when cur_valid=0.
- Output fire = pix_valid && pix_ready. On fire:
  - If idx < 7: idx increments.
  - If idx == 7: the word is finished.
- Load rule: the output register loads from the FIFO head (pop, idx set to 0, cur_valid=1) when the FIFO is non-empty and either cur_valid=0 or the word finishes this cycle.
  - If the word finishes and the FIFO is empty, cur_valid becomes 0.
- Latency: a word accepted at edge E0 into an empty FIFO with cur_valid=0 is loaded at E1. in1 appears on pix_out with pix_valid=1 after E1.
  - With pix_ready held at 1, the 8 pixels appear on 8 consecutive cycles.
  - Back-to-back words stream with no bubble.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. Push into a FIFO that was empty while the output also loads: the pushed word is not visible until the next cycle (no bypass).
- Stall: while pix_ready=0, pix_out, sof, eol, idx, col and row hold their values.
- Position counters advance only on fire:
  - col increments each fire. When col == IMG_WIDTH-1, col wraps to 0 and row increments.
  - When row == IMG_HEIGHT-1 and col wraps, row wraps to 0.
- Markers:
  - sof = pix_valid && col==0 && row==0.
  - eol = pix_valid && col==IMG_WIDTH-1.
  - frame_done is registered. It is 1 for exactly the cycle after the fire of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), and 0 otherwise.
- Word boundaries are aligned to lines, because IMG_WIDTH is a multiple of 8.

Test Plan:
- Reset: hold RST_N=0 for 2 edges with in_valid=1 -> pix_valid=0, pix_out=8'h00, sof=eol=frame_done=0, in_ready=1, and no word is captured.
- Single word: in1..in8=8'h01..8'h08, in_valid for 1 cycle at E0, pix_ready=1 -> pix_out is 01,02,..,08 on the cycles after E1..E8. sof=1 only with 01. pix_valid=0 after E9.
- Backpressure (FIFO_DEPTH=4): pix_ready=0, in_valid=1 continuously with distinct words -> exactly 5 words accepted (1 in the output register, 4 in the FIFO), then in_ready=0. Release pix_ready -> 40 pixels in order, no loss or duplication.
- Mid-word stall: pix_ready=0 while pix_out=03 for 3 cycles -> pix_out stays 03, and the next pixel after release is 04.
- Frame wrap (IMG_WIDTH=16, IMG_HEIGHT=2): stream 5 words -> eol on pixels 16 and 32. frame_done is a 1-cycle pulse after pixel 32 is accepted. Pixel 33 has sof=1.
- Reset mid-word: assert RST_N=0 while pix_out=05 and the FIFO holds 2 words -> after release pix_valid=0 and the FIFO is empty. The next pushed word begins with sof=1 at in1.
